mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous memory between an instruction port
//   (read only) and a data port (load/store). A three-state FSM handles one
//   access every three cycles:
//     IDLE  - pick a winner (round-robin on a tie) and latch its request
//     ISSUE - drive the memory strobe from the latched request
//     WAIT  - memory data is back; pulse the winner's ack and return its data
//   Addresses at or beyond DEPTH never reach the memory. They still complete,
//   but with err raised alongside the ack and zero read data.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   i_req/i_addr           instruction request and word address
//   i_ack/i_rdata          instruction completion pulse and read data
//   d_req/d_we/d_addr      data request, write enable and word address
//   d_wdata                store data
//   d_ack/d_rdata          data completion pulse and load data
//   err                    out-of-range flag, pulses with the ack
//   mem_en/mem_we          memory access and write strobes
//   mem_addr/mem_wdata     memory word address and write data
//   mem_rdata              memory read data (one-cycle read latency)
//   i_count/d_count        saturating per-port completed-access counters
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       i_count,
  output logic [15:0]       d_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q,      state_d;
  logic              lastData_q,   lastData_d;
  logic              portData_q,   portData_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              we_q,         we_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              outOfRange_q, outOfRange_d;
  logic [15:0]       iCount_q,     iCount_d;
  logic [15:0]       dCount_q,     dCount_d;

  logic              grantData;
  logic [ADDR_W-1:0] winAddr;
  logic              inIssue;
  logic              inWait;
  logic              rdataValid;

  // The data port wins when it is the only requester, or on a tie when the
  // instruction port was served last.
  always_comb begin
    grantData = d_req && (!i_req || !lastData_q);
    winAddr   = grantData ? d_addr : i_addr;
  end

  // Next-state logic: latch the winner in IDLE, walk through ISSUE and WAIT,
  // and bump the granted port's counter on its WAIT cycle (errors included).
  always_comb begin
    state_d      = state_q;
    lastData_d   = lastData_q;
    portData_d   = portData_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    outOfRange_d = outOfRange_q;
    iCount_d     = iCount_q;
    dCount_d     = dCount_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          portData_d   = grantData;
          lastData_d   = grantData;
          addr_d       = winAddr;
          we_d         = grantData && d_we;
          wdata_d      = grantData ? d_wdata : '0;
          outOfRange_d = ({1'b0, winAddr} >= DEPTH_W);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (portData_q) begin
          dCount_d = (dCount_q == 16'hFFFF) ? dCount_q : dCount_q + 16'd1;
        end else begin
          iCount_d = (iCount_q == 16'hFFFF) ? iCount_q : iCount_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. After reset the data port counts as last granted so the
  // first tie goes to the instruction port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lastData_q   <= 1'b1;
      portData_q   <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      outOfRange_q <= 1'b0;
      iCount_q     <= 16'd0;
      dCount_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      lastData_q   <= lastData_d;
      portData_q   <= portData_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      outOfRange_q <= outOfRange_d;
      iCount_q     <= iCount_d;
      dCount_q     <= dCount_d;
    end
  end

  // Output decode. Reset gates the strobes and acks combinationally so an
  // access caught mid-flight never writes memory and never acknowledges.
  always_comb begin
    inIssue    = (state_q == ISSUE) && !reset;
    inWait     = (state_q == WAIT) && !reset;
    rdataValid = !we_q && !outOfRange_q;

    mem_en    = inIssue && !outOfRange_q;
    mem_we    = inIssue && !outOfRange_q && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;

    i_ack   = inWait && !portData_q;
    d_ack   = inWait && portData_q;
    err     = inWait && outOfRange_q;
    i_rdata = (i_ack && rdataValid) ? mem_rdata : '0;
    d_rdata = (d_ack && rdataValid) ? mem_rdata : '0;

    i_count = iCount_q;
    d_count = dCount_q;
  end

endmodule
